// File: rtl/ysyx_24100027_ifu.sv
// Instruction fetch unit: one fetch/deliver/execute round at a time, with PC
// update from a commit pulse and a sticky, reset-only-clearable fetch fault.
module ysyx_24100027_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        PCActr,
   input  logic        PCBctr,
   input  logic [31:0] imm,
   input  logic [31:0] rs1,
   input  logic        commit_valid,
   output logic        req_valid,
   input  logic        req_ready,
   output logic [31:0] req_addr,
   input  logic        rsp_valid,
   input  logic [31:0] rsp_data,
   input  logic        rsp_err,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        fault
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_WAIT,
      S_DELIVER,
      S_EXEC,
      S_HALT
   } state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] inst_q;
   logic [31:0] inst_pc_q;
   logic        fault_q;
   logic        req_valid_q;
   logic        inst_valid_q;
   logic [31:0] addend_a;
   logic [31:0] addend_b;

   // NOTE: every variable assigned here gets a value on every path first,
   // otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      addend_a = PCActr ? imm : 32'd4;
      addend_b = PCBctr ? rs1 : pc_q;
      pc_d     = addend_a + addend_b;
      if (PCActr && PCBctr) begin
         pc_d[0] = 1'b0;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_FETCH;
         pc_q         <= RESET_PC;
         inst_q       <= 32'd0;
         inst_pc_q    <= 32'd0;
         fault_q      <= 1'b0;
         req_valid_q  <= 1'b0;
         inst_valid_q <= 1'b0;
      end else begin
         case (state_q)
            // req_valid is held low through reset and rises on the first edge.
            S_FETCH: begin
               if (req_valid_q && req_ready) begin
                  req_valid_q <= 1'b0;
                  state_q     <= S_WAIT;
               end else begin
                  req_valid_q <= 1'b1;
               end
            end
            S_WAIT: begin
               if (rsp_valid) begin
                  if (rsp_err) begin
                     fault_q <= 1'b1;
                     state_q <= S_HALT;
                  end else begin
                     inst_q       <= rsp_data;
                     inst_pc_q    <= pc_q;
                     inst_valid_q <= 1'b1;
                     state_q      <= S_DELIVER;
                  end
               end
            end
            S_DELIVER: begin
               if (inst_ready) begin
                  inst_valid_q <= 1'b0;
                  state_q      <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (commit_valid) begin
                  if (pc_d[1]) begin
                     fault_q <= 1'b1;
                     state_q <= S_HALT;
                  end else begin
                     pc_q        <= pc_d;
                     req_valid_q <= 1'b1;
                     state_q     <= S_FETCH;
                  end
               end
            end
            S_HALT: begin
               state_q <= S_HALT;
            end
            default: begin
               state_q <= S_HALT;
               fault_q <= 1'b1;
            end
         endcase
      end
   end

   assign req_valid  = req_valid_q;
   assign req_addr   = pc_q;
   assign inst_valid = inst_valid_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign fault      = fault_q;

endmodule

// File: tb/tb_ysyx_24100027_ifu.sv
// Bench for ysyx_24100027_ifu: directed scenarios plus randomized rounds
// checked against a PC/instruction model driven by the fetch-round rules.
module tb_ysyx_24100027_ifu;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        PCActr = 1'b0;
   logic        PCBctr = 1'b0;
   logic [31:0] imm = 32'd0;
   logic [31:0] rs1 = 32'd0;
   logic        commit_valid = 1'b0;
   logic        req_valid;
   logic        req_ready = 1'b0;
   logic [31:0] req_addr;
   logic        rsp_valid = 1'b0;
   logic [31:0] rsp_data = 32'd0;
   logic        rsp_err = 1'b0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        fault;

   always #5 clk = ~clk;

   ysyx_24100027_ifu #(.RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .PCActr       (PCActr),
      .PCBctr       (PCBctr),
      .imm          (imm),
      .rs1          (rs1),
      .commit_valid (commit_valid),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .rsp_err      (rsp_err),
      .inst_valid   (inst_valid),
      .inst_ready   (inst_ready),
      .inst         (inst),
      .inst_pc      (inst_pc),
      .fault        (fault)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] m_pc = RESET_PC;
   bit          m_halted = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference next-PC rule, in plain unsigned arithmetic.
   function automatic logic [31:0] model_next(input bit actr, input bit bctr,
                                              input logic [31:0] imm_v,
                                              input logic [31:0] rs1_v,
                                              input logic [31:0] pc);
      longint unsigned a, b, s;
      a = actr ? longint'(imm_v) : 64'd4;
      b = bctr ? longint'(rs1_v) : longint'(pc);
      s = (a + b) % 64'h1_0000_0000;
      if (actr && bctr) s = s - (s % 2);
      return s[31:0];
   endfunction

   function automatic bit misaligned(input logic [31:0] a);
      return (a % 4) >= 2;
   endfunction

   task automatic run_insn(input logic [31:0] word, input int rq_stall, input int rsp_dly,
                           input int in_stall, input int exec_dly, input bit err,
                           input bit actr, input bit bctr, input logic [31:0] imm_v,
                           input logic [31:0] rs1_v, input bit hold_rdy);
      logic [31:0] np;
      check("fetch.req_valid", 32'(req_valid), 32'd1);
      check("fetch.req_addr", req_addr, m_pc);
      inst_ready = hold_rdy;
      req_ready  = 1'b0;
      for (int i = 0; i < rq_stall; i++) begin
         rsp_valid = (i == 0);
         rsp_data  = 32'hDEAD_0000;
         tick();
         check("stall.req_valid", 32'(req_valid), 32'd1);
         check("stall.req_addr", req_addr, m_pc);
      end
      rsp_valid = 1'b0;
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      check("wait.req_valid", 32'(req_valid), 32'd0);
      for (int i = 0; i < rsp_dly; i++) begin
         commit_valid = (i == 0);
         PCActr = 1'b1;
         PCBctr = 1'b1;
         imm    = 32'h2;
         rs1    = 32'h0;
         tick();
         check("wait.inst_valid", 32'(inst_valid), 32'd0);
         check("wait.fault", 32'(fault), 32'd0);
      end
      commit_valid = 1'b0;
      rsp_valid = 1'b1;
      rsp_data  = word;
      rsp_err   = err;
      tick();
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      if (err) begin
         m_halted = 1'b1;
         check("err.fault", 32'(fault), 32'd1);
         check("err.req_valid", 32'(req_valid), 32'd0);
         check("err.inst_valid", 32'(inst_valid), 32'd0);
         return;
      end
      check("dlv.inst_valid", 32'(inst_valid), 32'd1);
      check("dlv.inst", inst, word);
      check("dlv.inst_pc", inst_pc, m_pc);
      if (!hold_rdy) begin
         for (int i = 0; i < in_stall; i++) begin
            rsp_valid    = (i == 0);
            rsp_data     = ~word;
            commit_valid = (i == 0);
            tick();
            check("dlv_hold.inst_valid", 32'(inst_valid), 32'd1);
            check("dlv_hold.inst", inst, word);
            check("dlv_hold.inst_pc", inst_pc, m_pc);
         end
         rsp_valid    = 1'b0;
         commit_valid = 1'b0;
         inst_ready   = 1'b1;
      end
      tick();
      inst_ready = hold_rdy;
      check("exec.inst_valid", 32'(inst_valid), 32'd0);
      check("exec.req_valid", 32'(req_valid), 32'd0);
      for (int i = 0; i < exec_dly; i++) begin
         rsp_valid = (i == 0);
         rsp_data  = 32'h0000_FFFF;
         tick();
         check("exec_idle.inst_valid", 32'(inst_valid), 32'd0);
         check("exec_idle.req_valid", 32'(req_valid), 32'd0);
         check("exec_idle.inst", inst, word);
      end
      rsp_valid    = 1'b0;
      PCActr       = actr;
      PCBctr       = bctr;
      imm          = imm_v;
      rs1          = rs1_v;
      commit_valid = 1'b1;
      tick();
      commit_valid = 1'b0;
      inst_ready   = 1'b0;
      np = model_next(actr, bctr, imm_v, rs1_v, m_pc);
      if (misaligned(np)) begin
         m_halted = 1'b1;
         check("misal.fault", 32'(fault), 32'd1);
         check("misal.req_valid", 32'(req_valid), 32'd0);
         check("misal.req_addr", req_addr, m_pc);
      end else begin
         m_pc = np;
         check("commit.fault", 32'(fault), 32'd0);
      end
   endtask

   task automatic halt_check();
      req_ready    = 1'b1;
      inst_ready   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rsp_valid    = 1'b1;
         commit_valid = 1'b1;
         tick();
         check("halt.req_valid", 32'(req_valid), 32'd0);
         check("halt.inst_valid", 32'(inst_valid), 32'd0);
         check("halt.fault", 32'(fault), 32'd1);
      end
      rsp_valid    = 1'b0;
      commit_valid = 1'b0;
      req_ready    = 1'b0;
      inst_ready   = 1'b0;
   endtask

   // Asynchronous reset pulse in the middle of a cycle, with a stray response.
   task automatic do_reset();
      #3;
      rst_n = 1'b0;
      #1;
      check("rst.fault", 32'(fault), 32'd0);
      check("rst.req_addr", req_addr, RESET_PC);
      check("rst.req_valid", 32'(req_valid), 32'd0);
      check("rst.inst_valid", 32'(inst_valid), 32'd0);
      check("rst.inst", inst, 32'd0);
      check("rst.inst_pc", inst_pc, 32'd0);
      rsp_valid = 1'b1;
      rsp_data  = 32'hBAD0_BAD0;
      #2;
      rst_n = 1'b1;
      tick();
      rsp_valid = 1'b0;
      check("post_rst.req_valid", 32'(req_valid), 32'd1);
      check("post_rst.req_addr", req_addr, RESET_PC);
      check("post_rst.inst_valid", 32'(inst_valid), 32'd0);
      check("post_rst.inst", inst, 32'd0);
      m_pc     = RESET_PC;
      m_halted = 1'b0;
   endtask

   initial begin
      logic [31:0] r_imm, r_rs1;
      int          kind;
      #12;
      check("reset.req_valid", 32'(req_valid), 32'd0);
      check("reset.inst_valid", 32'(inst_valid), 32'd0);
      check("reset.req_addr", req_addr, RESET_PC);
      check("reset.fault", 32'(fault), 32'd0);
      check("reset.inst", inst, 32'd0);
      check("reset.inst_pc", inst_pc, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("first_edge.req_valid", 32'(req_valid), 32'd1);

      run_insn(32'h0000_0013, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      check("seq.req_addr", req_addr, 32'h8000_0004);
      for (int k = 0; k < 3; k++) begin
         run_insn(32'h0000_0013 + k, 0, 1, 0, 1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      end
      check("seq4.req_addr", req_addr, 32'h8000_0010);
      run_insn(32'h0000_0063, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'd0, 1'b0);
      check("branch.req_addr", req_addr, 32'h8000_0000);
      run_insn(32'h0000_0067, 0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 32'h4, 32'h8000_1001, 1'b0);
      check("jalr.req_addr", req_addr, 32'h8000_1004);
      run_insn(32'h0000_0067, 0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 32'h1, 32'h8000_1001, 1'b0);
      check("jalr_misal.fault", 32'(fault), 32'd1);
      check("jalr_misal.req_addr", req_addr, 32'h8000_1004);
      halt_check();
      do_reset();

      run_insn(32'h1234_5678, 5, 2, 3, 1, 1'b0, 1'b0, 1'b1, 32'd0, 32'h0000_1000, 1'b0);
      check("unused_enc.req_addr", req_addr, 32'h0000_1004);
      run_insn(32'hCAFE_F00D, 1, 1, 0, 0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      halt_check();
      do_reset();

      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      rsp_valid = 1'b1;
      rsp_data  = 32'h0000_1234;
      tick();
      rsp_valid = 1'b0;
      check("midtx.inst", inst, 32'h0000_1234);
      do_reset();

      for (int n = 0; n < 60; n++) begin
         kind  = $urandom_range(0, 3);
         r_imm = $urandom;
         r_rs1 = $urandom;
         if ($urandom_range(0, 3) != 0) r_imm = r_imm & 32'hFFFF_FFFC;
         if ($urandom_range(0, 3) != 0) r_rs1 = r_rs1 & 32'hFFFF_FFFC;
         run_insn($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2),
                  ($urandom_range(0, 14) == 0), kind[0], kind[1], r_imm, r_rs1,
                  bit'($urandom_range(0, 1)));
         if (m_halted) begin
            halt_check();
            do_reset();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
